rx_frame_ctrl: RTL

Packet controller downstream of the asynchronous UART receiver. Consumes the receiver's byte stream (`dout`/`data_strobe`/`error`) and parses framed packets of the form SYNC, LEN, payload, CHECKSUM. Buffers the payload and hands it to the consumer over a valid/ready byte interface. Reports framing, parity, checksum and timeout errors, and counts them.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/rx_frame_ctrl_if.sv | 31 +++
 rtl/rx_frame_ctrl_gap_timer.sv | 39 +++
 rtl/rx_frame_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, frame/error enums and clogb2 helper for the
//                UART receiver, transmitter and packet controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } frame_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BADLEN  = 3'd1,
    ERR_CHKSUM  = 3'd2,
    ERR_PARITY  = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_OVERRUN = 3'd5
  } err_code_e;

  // Number of bits needed to hold values 0 .. value-1 (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_ctrl_if
//  Description : Valid/ready payload byte stream from the packet controller
//                (master) to its consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_ctrl_if;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic [7:0] pkt_len;

  modport master (
    output pkt_data,
    output pkt_valid,
    output pkt_last,
    output pkt_len,
    input  pkt_ready
  );

  modport slave (
    input  pkt_data,
    input  pkt_valid,
    input  pkt_last,
    input  pkt_len,
    output pkt_ready
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_ctrl_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : gap_timer
//  Description : Inter-byte idle timer. Counts enabled cycles since the last
//                clear and pulses expired on the TERMINAL-th such cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module gap_timer
  import uart_pkg::*;
#(
  parameter int TERMINAL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = clogb2(TERMINAL + 1);

  logic [CNT_W-1:0] cnt;

  // A clear in the terminal cycle wins, so the pulse is suppressed.
  assign expired = enable && !clear && (cnt == CNT_W'(TERMINAL - 1));

  // Idle-cycle counter; held at zero while disabled and restarted after expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_ctrl
//  Description : Parses SYNC/LEN/payload/CHECKSUM packets from the UART
//                receiver byte stream, buffers the payload, drains it over a
//                valid/ready stream and reports/counts aborted packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 19200,
  parameter int MAX_LEN       = 16,
  parameter int GAP_BYTES     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_strobe,
  input  logic                   rx_error,
  rx_frame_ctrl_if.master        pkt,
  output logic                   frame_err,
  output logic [2:0]             err_code,
  output logic [7:0]             err_count
);

  localparam int         IDX_W     = clogb2(MAX_LEN + 1);
  localparam int         GAP_TC    = GAP_BYTES * 11 * (CLK_FREQUENCY / BAUD_RATE);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frame_state_e     state;
  frame_state_e     next_state;
  logic [7:0]       len;
  logic [7:0]       sum;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd;
  logic [7:0]       buf_mem [MAX_LEN];
  err_code_e        err_code_reg;

  logic             abort;
  err_code_e        abort_code;
  logic             overrun;
  logic             len_ok;
  logic             wr_en;
  logic             csum_ok;
  logic             rd_adv;
  logic             last_byte;
  logic             gap_expired;
  logic             receiving;
  logic [7:0]       sum_chk;
  logic [7:0]       rd_byte;
  logic [IDX_W-1:0] idx_nxt;

  assign receiving = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign sum_chk   = sum + rx_data;
  assign idx_nxt   = idx + IDX_W'(1);
  assign last_byte = (rd == (len[IDX_W-1:0] - IDX_W'(1)));
  assign rd_adv    = pkt.pkt_valid && pkt.pkt_ready;

  gap_timer #(
    .TERMINAL (GAP_TC)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_strobe),
    .enable  (receiving),
    .expired (gap_expired)
  );

  // Stream outputs come straight from registered state, never from pkt_ready.
  assign pkt.pkt_valid = (state == ST_DRAIN);
  assign pkt.pkt_data  = pkt.pkt_valid ? rd_byte : 8'h00;
  assign pkt.pkt_last  = pkt.pkt_valid && last_byte;
  assign pkt.pkt_len   = len;
  assign err_code      = err_code_reg;

  // Read-side mux over the payload flops.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd == IDX_W'(i)) rd_byte = buf_mem[i];
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    overrun    = 1'b0;
    len_ok     = 1'b0;
    wr_en      = 1'b0;
    csum_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_strobe && !rx_error && (rx_data == SYNC_BYTE)) next_state = ST_LEN;
      end
      ST_LEN: begin
        if (rx_strobe) begin
          if (rx_error) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
            abort      = 1'b1;
            abort_code = ERR_BADLEN;
          end else begin
            len_ok     = 1'b1;
            next_state = ST_PAYLOAD;
          end
        end else if (gap_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      ST_PAYLOAD: begin
        if (rx_strobe) begin
          if (rx_error) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else begin
            wr_en = 1'b1;
            if (idx_nxt == len[IDX_W-1:0]) next_state = ST_CSUM;
          end
        end else if (gap_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      ST_CSUM: begin
        if (rx_strobe) begin
          if (rx_error) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else if (sum_chk == 8'h00) begin
            csum_ok    = 1'b1;
            next_state = ST_DRAIN;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CHKSUM;
          end
        end else if (gap_expired) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        overrun = rx_strobe;
        if (rd_adv && last_byte) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  // State, packet bookkeeping and error reporting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len          <= 8'h00;
      sum          <= 8'h00;
      idx          <= '0;
      rd           <= '0;
      frame_err    <= 1'b0;
      err_code_reg <= ERR_NONE;
      err_count    <= 8'h00;
    end else begin
      state     <= next_state;
      frame_err <= abort;
      if (len_ok) begin
        len <= rx_data;
        sum <= rx_data;
        idx <= '0;
      end
      if (wr_en) begin
        sum <= sum_chk;
        idx <= idx_nxt;
      end
      if (csum_ok) rd <= '0;
      if (rd_adv)  rd <= rd + IDX_W'(1);
      if (abort || overrun) begin
        err_code_reg <= abort ? abort_code : ERR_OVERRUN;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  // Payload flops; contents after an abort are irrelevant so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_en && (idx == IDX_W'(i))) buf_mem[i] <= rx_data;
    end
  end

endmodule
`default_nettype wire
